// File: rtl/ant_pkg.sv
// Shared types and helpers for the ant movement stage: heading encoding,
// default arena size and per-heading grid deltas.
package ant_pkg;

    localparam int unsigned GRID_W_DEF = 16;
    localparam int unsigned GRID_H_DEF = 16;
    localparam int unsigned BUMP_W     = 8;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_E = 2'd1,
        HEAD_S = 2'd2,
        HEAD_W = 2'd3
    } head_t;

    function automatic int head_dx(input head_t h);
        case (h)
            HEAD_E:  return 1;
            HEAD_W:  return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int head_dy(input head_t h);
        case (h)
            HEAD_N:  return 1;
            HEAD_S:  return -1;
            default: return 0;
        endcase
    endfunction

    // Opposing turn requests cancel out.
    function automatic head_t head_rot(input head_t h, input logic tl, input logic tr);
        case ({tl, tr})
            2'b10:   return head_t'(2'(h - 2'd1));
            2'b01:   return head_t'(2'(h + 2'd1));
            default: return h;
        endcase
    endfunction

endpackage

// File: rtl/ant_tick_gen.sv
// Step prescaler: tick_o is high for one cycle out of every TICK_DIV,
// during the cycle in which the free-running count sits at TICK_DIV-1.
module ant_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic CLK,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick is registered, so it is decoded one count early.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = (cnt_q == CW'(TICK_DIV - 2));
        if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ant_mover.sv
// Ant position/heading update and antenna sensing, driven by the step tick.
// Optional bump counter output is enabled by defining ANT_BUMP_CNT_EN.
module ant_mover
    import ant_pkg::*;
#(
    parameter int unsigned GRID_W     = GRID_W_DEF,
    parameter int unsigned GRID_H     = GRID_H_DEF,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned START_X    = 0,
    parameter int unsigned START_Y    = 0,
    parameter int unsigned START_HEAD = 1
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         FW,
    input  logic                         TLeft,
    input  logic                         TRight,
    input  logic [GRID_W*GRID_H-1:0]     wallMap,
    output logic [$clog2(GRID_W)-1:0]    posX,
    output logic [$clog2(GRID_H)-1:0]    posY,
    output logic [1:0]                   heading,
    output logic                         LAntenna,
    output logic                         RAntenna,
    output logic                         step
`ifdef ANT_BUMP_CNT_EN
    ,
    output logic [BUMP_W-1:0]            bumpCount
`endif
);

    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IW    = $clog2(CELLS);

    logic          tick;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    head_t         head_q, head_d;
    logic          step_q, step_d;
    logic          lant_q, lant_d;
    logic          rant_q, rant_d;
    int            ahead_x, ahead_y, right_x, right_y;
    logic          ahead_wall_c, right_wall_c;
`ifdef ANT_BUMP_CNT_EN
    logic [BUMP_W-1:0] bump_q, bump_d;
`endif

    ant_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK    (CLK),
        .reset  (reset),
        .tick_o (tick)
    );

    // Off-arena coordinates read as wall and never reach the map index.
    function automatic logic cell_blocked(input int x, input int y,
                                          input logic [CELLS-1:0] map);
        logic [IW-1:0] idx;
        idx = '0;
        if (x < 0 || y < 0 || x >= int'(GRID_W) || y >= int'(GRID_H)) begin
            return 1'b1;
        end
        idx = IW'(y * int'(GRID_W) + x);
        return map[idx];
    endfunction

    always_comb begin
        ahead_x      = int'(pos_x_q) + head_dx(head_q);
        ahead_y      = int'(pos_y_q) + head_dy(head_q);
        right_x      = int'(pos_x_q) + head_dx(head_t'(2'(head_q + 2'd1)));
        right_y      = int'(pos_y_q) + head_dy(head_t'(2'(head_q + 2'd1)));
        ahead_wall_c = cell_blocked(ahead_x, ahead_y, wallMap);
        right_wall_c = cell_blocked(right_x, right_y, wallMap);
    end

    // Forward uses the pre-rotation heading; rotation lands in the same tick.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        head_d  = head_q;
        step_d  = 1'b0;
        lant_d  = ahead_wall_c;
        rant_d  = right_wall_c;
`ifdef ANT_BUMP_CNT_EN
        bump_d  = bump_q;
`endif
        if (tick) begin
            step_d = 1'b1;
            head_d = head_rot(head_q, TLeft, TRight);
            if (FW && !ahead_wall_c) begin
                pos_x_d = XW'(ahead_x);
                pos_y_d = YW'(ahead_y);
            end
`ifdef ANT_BUMP_CNT_EN
            if (FW && ahead_wall_c && (bump_q != {BUMP_W{1'b1}})) begin
                bump_d = bump_q + BUMP_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pos_x_q <= XW'(START_X);
            pos_y_q <= YW'(START_Y);
            head_q  <= head_t'(2'(START_HEAD));
            step_q  <= 1'b0;
            lant_q  <= 1'b0;
            rant_q  <= 1'b0;
`ifdef ANT_BUMP_CNT_EN
            bump_q  <= '0;
`endif
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            head_q  <= head_d;
            step_q  <= step_d;
            lant_q  <= lant_d;
            rant_q  <= rant_d;
`ifdef ANT_BUMP_CNT_EN
            bump_q  <= bump_d;
`endif
        end
    end

    assign posX     = pos_x_q;
    assign posY     = pos_y_q;
    assign heading  = head_q;
    assign step     = step_q;
    assign LAntenna = lant_q;
    assign RAntenna = rant_q;
`ifdef ANT_BUMP_CNT_EN
    assign bumpCount = bump_q;
`endif

endmodule

// File: tb/tb_ant_mover.sv
// Bench for ant_mover: cycle-level reference model of the arena walk plus
// directed scenarios with hand-computed position/heading/antenna values.
module tb_ant_mover;

    localparam int GW = 16;
    localparam int GH = 16;
    localparam int TD = 4;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              FW = 1'b0;
    logic              TLeft = 1'b0;
    logic              TRight = 1'b0;
    logic [GW*GH-1:0]  wallMap = '0;
    logic [3:0]        posX;
    logic [3:0]        posY;
    logic [1:0]        heading;
    logic              LAntenna;
    logic              RAntenna;
    logic              step;
`ifdef ANT_BUMP_CNT_EN
    logic [7:0]        bumpCount;
`endif

    ant_mover #(
        .GRID_W     (GW),
        .GRID_H     (GH),
        .TICK_DIV   (TD),
        .START_X    (0),
        .START_Y    (0),
        .START_HEAD (1)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .FW       (FW),
        .TLeft    (TLeft),
        .TRight   (TRight),
        .wallMap  (wallMap),
        .posX     (posX),
        .posY     (posY),
        .heading  (heading),
        .LAntenna (LAntenna),
        .RAntenna (RAntenna),
        .step     (step)
`ifdef ANT_BUMP_CNT_EN
        ,
        .bumpCount(bumpCount)
`endif
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit wall2d [GW][GH];

    // Reference model: arena walk in plain integer coordinates.
    int   m_x, m_y, m_h, m_edges, m_bump;
    logic m_step, m_la, m_ra;

    function automatic bit blocked(input int x, input int y, input int h);
        int nx, ny;
        nx = x;
        ny = y;
        case (h)
            0: ny = y + 1;
            1: nx = x + 1;
            2: ny = y - 1;
            default: nx = x - 1;
        endcase
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) return 1'b1;
        return wall2d[nx][ny];
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_x <= 0; m_y <= 0; m_h <= 1; m_edges <= 0;
            m_step <= 1'b0; m_la <= 1'b0; m_ra <= 1'b0; m_bump <= 0;
        end else begin
            m_la    <= blocked(m_x, m_y, m_h);
            m_ra    <= blocked(m_x, m_y, (m_h + 1) % 4);
            m_step  <= ((m_edges % TD) == TD - 1);
            m_edges <= m_edges + 1;
            if ((m_edges % TD) == TD - 1) begin
                if (FW && !blocked(m_x, m_y, m_h)) begin
                    m_x <= m_x + ((m_h == 1) ? 1 : (m_h == 3) ? -1 : 0);
                    m_y <= m_y + ((m_h == 0) ? 1 : (m_h == 2) ? -1 : 0);
                end else if (FW) begin
                    m_bump <= (m_bump < 255) ? m_bump + 1 : 255;
                end
                if (TLeft && !TRight)      m_h <= (m_h + 3) % 4;
                else if (TRight && !TLeft) m_h <= (m_h + 1) % 4;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_posX", int'(posX), m_x);
            check("cyc_posY", int'(posY), m_y);
            check("cyc_heading", int'(heading), m_h);
            check("cyc_step", int'(step), int'(m_step));
            check("cyc_LAntenna", int'(LAntenna), int'(m_la));
            check("cyc_RAntenna", int'(RAntenna), int'(m_ra));
`ifdef ANT_BUMP_CNT_EN
            check("cyc_bumpCount", int'(bumpCount), m_bump);
`endif
        end
    end

    task automatic set_wall(input int x, input int y, input bit v);
        wall2d[x][y] = v;
        wallMap[8'(y * GW + x)] = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Hold commands until the model's tick edge; leaves time at T+1 (+1 unit).
    task automatic do_tick(input logic fw, input logic tl, input logic tr);
        bit found;
        found = 1'b0;
        @(negedge CLK);
        FW = fw; TLeft = tl; TRight = tr;
        for (int i = 0; i < 2 * TD && !found; i++) begin
            @(posedge CLK);
            #1;
            if (m_step) found = 1'b1;
        end
        FW = 1'b0; TLeft = 1'b0; TRight = 1'b0;
        if (!found) check("tick_timeout", 0, 1);
    endtask

    task automatic check_start(input string tag);
        check({tag, "_posX"}, int'(posX), 0);
        check({tag, "_posY"}, int'(posY), 0);
        check({tag, "_heading"}, int'(heading), 1);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_LAntenna"}, int'(LAntenna), 0);
        check({tag, "_RAntenna"}, int'(RAntenna), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fw, tl, tr;
        for (int x = 0; x < GW; x++)
            for (int y = 0; y < GH; y++) wall2d[x][y] = 1'b0;
        reset = 1'b0;
        wait_edges(2);
        chk_en = 1'b1;
        check_start("reset");
        @(negedge CLK);
        reset = 1'b1;

        // Straight run east on an empty map.
        do_tick(1, 0, 0);
        check("run1_posX", int'(posX), 1);
        check("run1_step", int'(step), 1);
        do_tick(1, 0, 0);
        check("run2_posX", int'(posX), 2);
        do_tick(1, 0, 0);
        check("run3_posX", int'(posX), 3);
        check("run3_posY", int'(posY), 0);
        repeat (12) do_tick(1, 0, 0);
        check("east_edge_posX", int'(posX), 15);
        wait_edges(1);
        check("east_edge_step_low", int'(step), 0);
        check("east_edge_LAntenna", int'(LAntenna), 1);
        check("east_edge_RAntenna", int'(RAntenna), 1);
        do_tick(1, 0, 0);
        check("blocked_posX", int'(posX), 15);
        check("blocked_step", int'(step), 1);
`ifdef ANT_BUMP_CNT_EN
        check("blocked_bump", int'(bumpCount), 1);
`endif

        // Navigate to (5,5) heading N.
        do_tick(0, 1, 0);
        check("turn_north", int'(heading), 0);
        repeat (5) do_tick(1, 0, 0);
        do_tick(0, 1, 0);
        repeat (10) do_tick(1, 0, 0);
        do_tick(0, 0, 1);
        check("at55_posX", int'(posX), 5);
        check("at55_posY", int'(posY), 5);
        check("at55_heading", int'(heading), 0);

        set_wall(6, 5, 1'b1);
        wait_edges(2);
        check("wall_RAntenna", int'(RAntenna), 1);
        check("wall_LAntenna", int'(LAntenna), 0);
        do_tick(0, 0, 1);
        check("rotE_heading", int'(heading), 1);
        check("rotE_LAntenna_T1", int'(LAntenna), 0);
        wait_edges(1);
        check("rotE_LAntenna_T2", int'(LAntenna), 1);
        check("rotE_RAntenna_T2", int'(RAntenna), 0);

        do_tick(0, 1, 0);
        do_tick(1, 1, 0);
        check("fwturn_posX", int'(posX), 5);
        check("fwturn_posY", int'(posY), 6);
        check("fwturn_heading", int'(heading), 3);
        do_tick(0, 1, 1);
        check("bothturn_heading", int'(heading), 3);
        check("bothturn_posY", int'(posY), 6);

        // Reach (3,7), then reset mid-count.
        repeat (2) do_tick(1, 0, 0);
        do_tick(0, 0, 1);
        do_tick(1, 0, 0);
        check("at37_posX", int'(posX), 3);
        check("at37_posY", int'(posY), 7);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check_start("midreset");
        @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < TD - 1; i++) begin
            wait_edges(1);
            check("restart_no_step", int'(step), 0);
        end
        wait_edges(1);
        check("restart_first_step", int'(step), 1);

        // Closed loop on a random obstacle field driven by the antennas.
        for (int x = 0; x < GW; x++)
            for (int y = 0; y < GH; y++)
                set_wall(x, y, ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
        set_wall(0, 0, 1'b0);
        for (int t = 0; t < 200; t++) begin
            wait_edges(2);
            fw = 1'b0; tl = 1'b0; tr = 1'b0;
            if (!LAntenna) begin
                fw = 1'b1;
                tl = ($urandom_range(0, 7) == 0);
            end else if (!RAntenna) begin
                tr = 1'b1;
            end else begin
                tl = 1'b1;
            end
            do_tick(fw, tl, tr);
        end
        wait_edges(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ant_mover.md
# ant_mover

Movement and sensing stage downstream of the ant control FSM: consumes the per-cycle FW/TLeft/TRight commands, applies them to the ant's grid position and heading once per step tick, and generates the LAntenna/RAntenna contact signals fed back to the FSM. It closes the control loop between the FSM and the maze/arena model and drives the display stage through posX/posY/heading.

## Interface
- GRID_W, 16: arena width in cells (x = 0..GRID_W-1)
- GRID_H, 16: arena height in cells (y = 0..GRID_H-1)
- TICK_DIV, 25000000: CLK cycles per step tick (>= 2)
- START_X, 0 / START_Y, 0: reset position
- START_HEAD, 1: reset heading (0=N, 1=E, 2=S, 3=W)
- CLK  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-low reset
- FW  input  1  move forward one cell on tick
- TLeft  input  1  rotate heading -1 (mod 4) on tick
- TRight  input  1  rotate heading +1 (mod 4) on tick
- wallMap  input  GRID_W*GRID_H  1 = wall; bit index y*GRID_W+x; treated as static
- posX  output  clog2(GRID_W)  current x
- posY  output  clog2(GRID_H)  current y
- heading  output  2  current heading
- LAntenna  output  1  cell ahead is wall or outside arena
- RAntenna  output  1  cell to the right (heading+1) is wall or outside arena
- step  output  1  one-cycle pulse, cycle after each tick update

## Operation
- Tick generator: counter 0..TICK_DIV-1, wraps; tick asserted in the cycle counter == TICK_DIV-1.
- On tick, FW/TLeft/TRight are sampled that cycle; off-tick they are ignored.
- Direction deltas: N y+1, E x+1, S y-1, W x-1.
- Forward: uses heading *before* rotation. If ahead cell is in-arena and wallMap bit is 0, position moves one cell; otherwise blocked, position holds.
- Rotation: TLeft only -> heading-1; TRight only -> heading+1; both or neither -> unchanged. Rotation applies in the same tick as forward.
- No wrap-around: x=0 facing W, x=GRID_W-1 facing E, y=0 facing S, y=GRID_H-1 facing N are all "outside" = wall; out-of-range arithmetic must never index wallMap.
- Antennas are recomputed every cycle from registered posX/posY/heading and wallMap, and registered.
- Reset (any time, including mid-tick): posX=START_X, posY=START_Y, heading=START_HEAD, counter=0, step=0, LAntenna=0, RAntenna=0.

## Timing
- Tick at cycle T: posX/posY/heading update at edge ending T (visible T+1).
- step high during T+1 only.
- LAntenna/RAntenna reflect new state from T+2 (one registered stage after state update).
- After reset release, antennas valid from second rising edge; first tick no earlier than TICK_DIV cycles after release.
- Blocked forward still pulses step.

## Configuration
- ANT_BUMP_CNT_EN defined: adds output bumpCount (8 bits), reset 0, increments on every tick where FW=1 and the move is blocked, saturates at 255; updates with position (visible T+1).
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Package ant_pkg: heading constants HEAD_N/E/S/W, 2-bit heading typedef, default GRID_W/GRID_H, delta-x/delta-y helper function.
- Sub-module ant_tick_gen: prescaler with TICK_DIV parameter, outputs tick; reset as above.
- Remaining logic (position/heading registers, wall probe, antenna registers, optional bump counter) in ant_mover.

## Test plan
- Reset at START (0,0,E), empty map, TICK_DIV=4, FW=1 held -> posX 1,2,3 on successive ticks, step pulses every 4 cycles, posY 0.
- At (15,0) heading E, FW=1 -> blocked, posX stays 15, LAntenna=1; bumpCount 0->1 with ANT_BUMP_CNT_EN.
- At (5,5) heading N, TLeft=1 FW=1 -> pos (5,6), heading W; TLeft=1 TRight=1 FW=0 -> heading unchanged.
- Wall at (6,5), ant at (5,5) heading N -> RAntenna=1, LAntenna=0; rotate E -> LAntenna=1 from T+2.
- Assert reset mid-count with ant at (3,7) -> immediate return to START state, step=0, counter restarts.
- Closed loop with antFSM, perimeter-only map, 200 ticks -> ant never leaves arena, posX/posY always in range.
